uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_ram.sv | 34 +++
 rtl/uart_tx_fifo.sv | 101 ++++++++++
 tb/tb_uart_tx_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART transmit path
// Contents:
//   DATA_W        - width of one UART character (bits)
//   DEFAULT_DEPTH - default number of entries in the transmit FIFO
package uart_pkg;

  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write index
//   wdata  - write byte
//   raddr  - read index
//   rdata  - byte at raddr (combinational)
// Storage is deliberately not reset; the pointers in the parent decide validity.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through transmit FIFO with level, threshold and overflow flags
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   enable        - UART global enable; low holds the FIFO flushed
//   flush         - one-cycle flush request
//   wr_en/wr_data - push request and byte
//   data_ready    - transmitter accepts the head byte this cycle
//   data_valid    - head byte present (FIFO not empty)
//   data_out      - head byte
//   level         - occupancy 0..DEPTH
//   full, empty   - occupancy flags
//   tx_thresh     - low-watermark threshold
//   thresh_hit    - level <= tx_thresh
//   overflow      - sticky: a push was dropped while full
//   clr_overflow  - clears overflow (a simultaneous drop keeps it set)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              data_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty,
  input  logic [AW:0]       tx_thresh,
  output logic              thresh_hit,
  output logic              overflow,
  input  logic              clr_overflow
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the indices coincide.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        pop;
  logic        push;
  logic        drop;
  logic        clear_all;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level      = wr_ptr - rd_ptr;
  assign data_valid = !empty;
  assign thresh_hit = (level <= tx_thresh);

  assign pop       = data_valid && data_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = wr_en && (!full || pop);
  assign drop      = wr_en && full && !pop;
  assign clear_all = flush || !enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear_all) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Flushing does not touch the sticky flag; only reset and clr_overflow do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push && !clear_all),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int THR   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          flush;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          data_ready;
  logic          data_valid;
  logic [7:0]    data_out;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic [AW:0]   tx_thresh;
  logic          thresh_hit;
  logic          overflow;
  logic          clr_overflow;

  logic [7:0] q[$];
  int total  = 0;
  int passed = 0;
  int mlevel = 0;
  bit movf   = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .data_ready   (data_ready),
    .data_valid   (data_valid),
    .data_out     (data_out),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .tx_thresh    (tx_thresh),
    .thresh_hit   (thresh_hit),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: every accepted head byte must match the oldest expected byte.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n && data_valid && data_ready) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL pop_unexpected: got 0x%02h expected no byte", data_out);
      end else begin
        e = q.pop_front();
        if (data_out == e) passed++;
        else $display("FAIL pop_data: got 0x%02h expected 0x%02h", data_out, e);
      end
    end
  end

  // Drive one cycle at posedge+1, update the expected state, return at next posedge+1.
  task automatic drive(input bit wr, input logic [7:0] d, input bit rdy,
                       input bit fl, input bit en, input bit clr);
    bit pop, acc, set;
    wr_en = wr; wr_data = d; data_ready = rdy; flush = fl; enable = en; clr_overflow = clr;
    pop = (mlevel > 0) && rdy;
    acc = wr && ((mlevel < DEPTH) || pop);
    set = wr && (mlevel == DEPTH) && !pop;
    if (fl || !en) begin
      q.delete();
      mlevel = 0;
    end else begin
      if (acc) q.push_back(d);
      mlevel = mlevel + int'(acc) - int'(pop);
    end
    if (set) movf = 1'b1;
    else if (clr) movf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag);
    chk({tag, "_level"}, int'(level), mlevel);
    chk({tag, "_full"}, int'(full), int'(mlevel == DEPTH));
    chk({tag, "_empty"}, int'(empty), int'(mlevel == 0));
    chk({tag, "_valid"}, int'(data_valid), int'(mlevel != 0));
    chk({tag, "_ovf"}, int'(overflow), int'(movf));
    chk({tag, "_thr"}, int'(thresh_hit), int'(mlevel <= THR));
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    data_ready = 1'b0; tx_thresh = THR[AW:0]; clr_overflow = 1'b0;
    #12;
    status("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full with 0x00..0x0F, transmitter stalled.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);
    // 17th push dropped, overflow set.
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    status("ovf");
    // Clear concurrent with another drop: set wins.
    drive(1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf_clr_vs_set", int'(overflow), 1);
    idle();
    chk("ovf_kept", int'(overflow), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf_cleared", int'(overflow), 0);

    // Drain; threshold rises once level reaches 4. Monitor checks 0x00..0x0F order.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("drain_level", int'(level), DEPTH - 1 - i);
      chk("drain_thr", int'(thresh_hit), int'((DEPTH - 1 - i) <= THR));
    end
    status("drained");

    // Push + pop at level 1.
    drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pp1_level", int'(level), 1);
    status("pp1");
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // Push + pop at full.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ppf_level", int'(level), 16);
    status("ppf");

    // Flush at full, then flush with a concurrent push at level 5.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    status("flush_full");
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_flush_level", int'(level), 5);
    drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("flush_level", int'(level), 0);
    status("flush5");
    // Same with enable low.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disable_level", int'(level), 0);
    status("disable");
    // Discarded bytes must not reappear.
    drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    status("after_flush");

    // Async reset mid-drain at level 7 with overflow set.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_level", int'(level), 7);
    chk("pre_rst_ovf", int'(overflow), 1);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete(); mlevel = 0; movf = 1'b0;
    data_ready = 1'b0; wr_en = 1'b0;
    status("async_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_head", int'(data_out), 8'h5A);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    status("final");
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
